lvds_rx_init_seq: RTL and testbench
===================================

// Module: lvds_rx_init_seq
// PURPOSE
//  Parametrised reset/lock sequencer for a multi-channel LVDS receiver block.
//  Drives PLL reset, RX reset, per-channel FIFO and CDA resets in order, qualifies PLL
//  lock stability, waits for all DPA locks, and adds timeouts, bounded retry and lock-loss recovery.
//  Sits between the board reset and the LVDS RX IP core; done gates downstream deserialised data.
// PARAMETERS
//  NUM_CH          4      number of LVDS RX channels (1..32)
//  PLL_RST_CYC     4      cycles pll_areset held high per attempt (>=1)
//  LOCK_STABLE_CYC 20     consecutive cycles rx_locked must be high before rx_reset release
//  FIFO_RST_CYC    1      rx_fifo_reset pulse width, cycles (>=1)
//  CDA_RST_CYC     1      rx_cda_reset pulse width, cycles (>=1)
//  TIMEOUT_CYC     65535  max cycles in WAIT_LOCK or DPA_WAIT before an attempt fails
//  MAX_RETRY       3      failed attempts allowed before FAIL (>=1)
// PORTS
//  inclock        in   1       reference clock, all logic on rising edge
//  rst_n          in   1       asynchronous active-low reset
//  start          in   1       level; begins sequence when high in IDLE or FAIL
//  rx_locked      in   1       PLL lock from RX core (treated as synchronous to inclock)
//  rx_dpa_locked  in   NUM_CH  per-channel DPA lock
//  pll_areset     out  1       PLL reset to RX core
//  rx_reset       out  1       RX core reset
//  rx_fifo_reset  out  NUM_CH  per-channel FIFO reset
//  rx_cda_reset   out  NUM_CH  per-channel CDA (bit-slip) reset
//  done           out  1       sequence complete, link usable
//  error          out  1       MAX_RETRY attempts exhausted
//  lock_lost      out  1       1-cycle pulse: rx_locked dropped while in DONE
//  retry_cnt      out  $clog2(MAX_RETRY+1)  failed attempts in current run
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; pll_areset=1, rx_reset=1; fifo/cda resets=0;
//   done=0, error=0, lock_lost=0, retry_cnt=0, all counters=0. All outputs registered.
//  States: IDLE, PLL_RST, WAIT_LOCK, DPA_WAIT, FIFO_RST, CDA_RST, DONE, FAIL.
//  IDLE: pll_areset=1, rx_reset=1. start=1 -> PLL_RST, retry_cnt<=0.
//  PLL_RST: pll_areset=1 exactly PLL_RST_CYC cycles, then pll_areset=0 -> WAIT_LOCK.
//  WAIT_LOCK: stab counter +1 each cycle rx_locked=1, cleared to 0 on any rx_locked=0.
//   stab==LOCK_STABLE_CYC -> rx_reset<=0, -> DPA_WAIT (first cycle of DPA_WAIT has rx_reset=0).
//  DPA_WAIT: &rx_dpa_locked=1 in same cycle -> FIFO_RST. rx_locked=0 here = attempt failure.
//  FIFO_RST: all rx_fifo_reset=1 for FIFO_RST_CYC cycles -> CDA_RST.
//  CDA_RST: rx_cda_reset pulse (see CONFIGURATION) -> DONE.
//  DONE: done=1. rx_locked=0 -> done<=0, lock_lost pulse, retry_cnt<=0, rx_reset<=1, -> PLL_RST.
//  Timeout: one counter, cleared on entry to WAIT_LOCK and DPA_WAIT; reaching TIMEOUT_CYC fails attempt.
//  Attempt failure: retry_cnt+1; if new value==MAX_RETRY -> FAIL else rx_reset<=1 -> PLL_RST.
//  FAIL: error=1, pll_areset=1, rx_reset=1, done=0. start=1 -> clear error, retry_cnt<=0, -> PLL_RST.
//  Simultaneous: timeout and lock-stable/all-DPA same cycle -> success wins.
//  start ignored outside IDLE/FAIL. rst_n mid-sequence: immediate return to reset values.
//  Counter widths $clog2(max+1); no wrap: counters saturate/clear on state change.
// CONFIGURATION
//  LVDS_INIT_PERCH_CDA_EN defined: CDA_RST pulses channels sequentially, ch0 first,
//   each rx_cda_reset[i] high CDA_RST_CYC cycles, 1 idle cycle between channels;
//   DONE entered after last channel's gap. Total NUM_CH*(CDA_RST_CYC+1) cycles.
//  Undefined: all rx_cda_reset bits high together CDA_RST_CYC cycles, then DONE.
// TESTING
//  1 Nominal (NUM_CH=4): start=1, rx_locked=1 steady, DPA all high -> pll_areset low after 4 cyc,
//    rx_reset low 20 cyc later, fifo pulse 1 cyc, cda pulse 1 cyc, done=1, error=0.
//  2 Lock glitch: rx_locked drops at stab=15 -> counter restarts; rx_reset release 20 cyc after regain.
//  3 DPA timeout (TIMEOUT_CYC=100): ch2 DPA held low -> 3 attempts, retry_cnt 1,2,3, FAIL, error=1,
//    pll_areset=1; start=1 then ch2 high -> done=1, retry_cnt=0.
//  4 Lock loss in DONE: drop rx_locked 1 cyc -> lock_lost one pulse, done=0, pll_areset=1 next cycle,
//    sequence reruns to done=1.
//  5 rst_n asserted in FIFO_RST -> same-cycle async: fifo reset=0, pll_areset=1, rx_reset=1, state IDLE.
//  6 LVDS_INIT_PERCH_CDA_EN, CDA_RST_CYC=2: rx_cda_reset = 0001,0001,0,0010,0010,0,... then done.

Source files
------------

// File: rtl/lvds_rx_init_seq.sv
// Reset/lock sequencer for a multi-channel LVDS receiver: PLL reset, lock qualification, DPA wait,
// FIFO/CDA reset pulses, timeouts with bounded retry. Define LVDS_INIT_PERCH_CDA_EN for per-channel CDA resets.
module lvds_rx_init_seq #(
  parameter int NUM_CH          = 4,
  parameter int PLL_RST_CYC     = 4,
  parameter int LOCK_STABLE_CYC = 20,
  parameter int FIFO_RST_CYC    = 1,
  parameter int CDA_RST_CYC     = 1,
  parameter int TIMEOUT_CYC     = 65535,
  parameter int MAX_RETRY       = 3
) (
  input  logic                           inclock,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           rx_locked,
  input  logic [NUM_CH-1:0]              rx_dpa_locked,
  output logic                           pll_areset,
  output logic                           rx_reset,
  output logic [NUM_CH-1:0]              rx_fifo_reset,
  output logic [NUM_CH-1:0]              rx_cda_reset,
  output logic                           done,
  output logic                           error,
  output logic                           lock_lost,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);
  // state     | meaning
  // S_IDLE    | post-reset, all resets asserted, waiting for start
  // S_PLL_RST | pll_areset held for PLL_RST_CYC cycles
  // S_WAIT    | qualifying rx_locked stability, timeout running
  // S_DPA     | rx_reset released, waiting for every DPA lock, timeout running
  // S_FIFO    | rx_fifo_reset pulse
  // S_CDA     | rx_cda_reset pulse(s)
  // S_DONE    | link usable, watching for lock loss
  // S_FAIL    | retries exhausted, waiting for start
  typedef enum logic [2:0] {
    S_IDLE, S_PLL_RST, S_WAIT, S_DPA, S_FIFO, S_CDA, S_DONE, S_FAIL
  } state_t;

  localparam int PH_MAX0 = (PLL_RST_CYC > FIFO_RST_CYC) ? PLL_RST_CYC : FIFO_RST_CYC;
  localparam int PH_MAX  = (PH_MAX0 > CDA_RST_CYC) ? PH_MAX0 : CDA_RST_CYC;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  localparam int STAB_W  = $clog2(LOCK_STABLE_CYC + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  state_t             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               pll_q, pll_d, rxr_q, rxr_d;
  logic [NUM_CH-1:0]  fifo_q, fifo_d, cda_q, cda_d;
  logic               done_q, done_d, err_q, err_d, ll_q, ll_d;
  logic               fail;
`ifdef LVDS_INIT_PERCH_CDA_EN
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  logic [CH_W-1:0]    ch_q, ch_d;
`endif

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    stab_d  = stab_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    pll_d   = pll_q;
    rxr_d   = rxr_q;
    fifo_d  = fifo_q;
    cda_d   = cda_q;
    done_d  = done_q;
    err_d   = err_q;
    ll_d    = 1'b0;
    fail    = 1'b0;
`ifdef LVDS_INIT_PERCH_CDA_EN
    ch_d    = ch_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_PLL_RST;
        retry_d = '0;
        ph_d    = '0;
      end
      S_PLL_RST: begin
        if (ph_q == PH_W'(PLL_RST_CYC - 1)) begin
          pll_d   = 1'b0;
          state_d = S_WAIT;
          stab_d  = '0;
          tmo_d   = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_WAIT: begin
        stab_d = rx_locked ? stab_q + STAB_W'(1) : '0;
        tmo_d  = tmo_q + TMO_W'(1);
        // success is tested first so it wins over a coincident timeout
        if (rx_locked && stab_q == STAB_W'(LOCK_STABLE_CYC - 1)) begin
          rxr_d   = 1'b0;
          state_d = S_DPA;
          stab_d  = '0;
          tmo_d   = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          fail = 1'b1;
        end
      end
      S_DPA: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (!rx_locked) begin
          fail = 1'b1;
        end else if (&rx_dpa_locked) begin
          state_d = S_FIFO;
          fifo_d  = '1;
          ph_d    = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          fail = 1'b1;
        end
      end
      S_FIFO: begin
        if (ph_q == PH_W'(FIFO_RST_CYC - 1)) begin
          fifo_d  = '0;
          state_d = S_CDA;
          ph_d    = '0;
`ifdef LVDS_INIT_PERCH_CDA_EN
          cda_d   = NUM_CH'(1);
          ch_d    = '0;
`else
          cda_d   = '1;
`endif
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_CDA: begin
`ifdef LVDS_INIT_PERCH_CDA_EN
        // each channel slot is CDA_RST_CYC pulse cycles plus one idle gap
        if (ph_q == PH_W'(CDA_RST_CYC)) begin
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            ch_d  = ch_q + CH_W'(1);
            ph_d  = '0;
            cda_d = NUM_CH'(1) << (ch_q + CH_W'(1));
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
          if (ph_q == PH_W'(CDA_RST_CYC - 1)) cda_d = '0;
        end
`else
        if (ph_q == PH_W'(CDA_RST_CYC - 1)) begin
          cda_d   = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
`endif
      end
      S_DONE: if (!rx_locked) begin
        done_d  = 1'b0;
        ll_d    = 1'b1;
        retry_d = '0;
        rxr_d   = 1'b1;
        pll_d   = 1'b1;
        state_d = S_PLL_RST;
        ph_d    = '0;
      end
      S_FAIL: if (start) begin
        err_d   = 1'b0;
        retry_d = '0;
        state_d = S_PLL_RST;
        ph_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      retry_d = retry_q + RTY_W'(1);
      rxr_d   = 1'b1;
      pll_d   = 1'b1;
      stab_d  = '0;
      tmo_d   = '0;
      ph_d    = '0;
      if (retry_q + RTY_W'(1) == RTY_W'(MAX_RETRY)) begin
        err_d   = 1'b1;
        state_d = S_FAIL;
      end else begin
        state_d = S_PLL_RST;
      end
    end
  end

  always_ff @(posedge inclock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      stab_q  <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
      pll_q   <= 1'b1;
      rxr_q   <= 1'b1;
      fifo_q  <= '0;
      cda_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ll_q    <= 1'b0;
`ifdef LVDS_INIT_PERCH_CDA_EN
      ch_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      stab_q  <= stab_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      pll_q   <= pll_d;
      rxr_q   <= rxr_d;
      fifo_q  <= fifo_d;
      cda_q   <= cda_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ll_q    <= ll_d;
`ifdef LVDS_INIT_PERCH_CDA_EN
      ch_q    <= ch_d;
`endif
    end
  end

  assign pll_areset    = pll_q;
  assign rx_reset      = rxr_q;
  assign rx_fifo_reset = fifo_q;
  assign rx_cda_reset  = cda_q;
  assign done          = done_q;
  assign error         = err_q;
  assign lock_lost     = ll_q;
  assign retry_cnt     = retry_q;
endmodule

// File: tb/tb_lvds_rx_init_seq.sv
// Bench for lvds_rx_init_seq: directed scenario sequence with randomised lock/DPA timing and start noise,
// expected outputs derived phase by phase from the sequencing rules.
module tb_lvds_rx_init_seq;
  localparam int NUM_CH          = 4;
  localparam int PLL_RST_CYC     = 4;
  localparam int LOCK_STABLE_CYC = 20;
  localparam int FIFO_RST_CYC    = 1;
`ifdef LVDS_INIT_PERCH_CDA_EN
  localparam int CDA_RST_CYC     = 2;
`else
  localparam int CDA_RST_CYC     = 1;
`endif
  localparam int TIMEOUT_CYC     = 100;
  localparam int MAX_RETRY       = 3;
  localparam int RW              = $clog2(MAX_RETRY + 1);

  logic              inclock = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              rx_locked = 1'b0;
  logic [NUM_CH-1:0] rx_dpa_locked = '0;
  logic              pll_areset, rx_reset, done, error, lock_lost;
  logic [NUM_CH-1:0] rx_fifo_reset, rx_cda_reset;
  logic [RW-1:0]     retry_cnt;

  lvds_rx_init_seq #(
    .NUM_CH(NUM_CH), .PLL_RST_CYC(PLL_RST_CYC), .LOCK_STABLE_CYC(LOCK_STABLE_CYC),
    .FIFO_RST_CYC(FIFO_RST_CYC), .CDA_RST_CYC(CDA_RST_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .inclock(inclock), .rst_n(rst_n), .start(start), .rx_locked(rx_locked),
    .rx_dpa_locked(rx_dpa_locked), .pll_areset(pll_areset), .rx_reset(rx_reset),
    .rx_fifo_reset(rx_fifo_reset), .rx_cda_reset(rx_cda_reset), .done(done),
    .error(error), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
  );

  always #5 inclock = ~inclock;

  int errors = 0;
  int checks = 0;
  logic              e_pll, e_rxr, e_done, e_err, e_ll;
  logic [NUM_CH-1:0] e_fifo, e_cda;
  int                e_retry;
  bit                noise = 1'b0;
  int                fail_plan[$];
  logic [NUM_CH-1:0] stuck_mask = '0;
  int                res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pll_areset"}, 32'(pll_areset), 32'(e_pll));
    check({tag, ".rx_reset"}, 32'(rx_reset), 32'(e_rxr));
    check({tag, ".fifo"}, 32'(rx_fifo_reset), 32'(e_fifo));
    check({tag, ".cda"}, 32'(rx_cda_reset), 32'(e_cda));
    check({tag, ".done"}, 32'(done), 32'(e_done));
    check({tag, ".error"}, 32'(error), 32'(e_err));
    check({tag, ".lock_lost"}, 32'(lock_lost), 32'(e_ll));
    check({tag, ".retry"}, 32'(retry_cnt), 32'(e_retry));
  endtask

  task automatic set_reset_exp();
    e_pll = 1'b1; e_rxr = 1'b1; e_fifo = '0; e_cda = '0;
    e_done = 1'b0; e_err = 1'b0; e_ll = 1'b0; e_retry = 0;
  endtask

  // lock_lost is a single-cycle pulse, so it is expected low unless a scenario says otherwise
  task automatic step();
    if (noise) start = 1'($urandom_range(0, 1));
    @(posedge inclock);
    #1;
    e_ll = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    set_reset_exp();
    check_all({tag, ".async"});
    @(negedge inclock);
    rst_n = 1'b1;
    noise = 1'b0;
    start = 1'b0;
    step();
    check_all({tag, ".idle"});
  endtask

  task automatic begin_run(input string tag);
    noise = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    e_retry = 0; e_err = 1'b0; e_pll = 1'b1; e_rxr = 1'b1;
    check_all(tag);
  endtask

  task automatic phase_pll();
    for (int i = 1; i < PLL_RST_CYC; i++) begin
      step();
      check_all("pll_rst");
    end
    step();
    e_pll = 1'b0;
    check_all("pll_rel");
  endtask

  task automatic phase_wait(input int mode, input int g_at, input int g_len, output bit ok);
    int c;
    c = 0;
    ok = 1'b0;
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      rx_locked = (mode == 1 || (k >= g_at && k < g_at + g_len)) ? 1'b0 : 1'b1;
      step();
      c = rx_locked ? c + 1 : 0;
      if (c == LOCK_STABLE_CYC) begin
        e_rxr = 1'b0;
        check_all("rx_rst_rel");
        ok = 1'b1;
        return;
      end
      if (k == TIMEOUT_CYC) return;
      check_all("wait_lock");
    end
  endtask

  task automatic phase_dpa(input int delay, input logic [NUM_CH-1:0] stuck, input int drop_at,
                           output bit ok);
    logic [NUM_CH-1:0] d;
    ok = 1'b0;
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      d = NUM_CH'($urandom) | ((k >= delay) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}});
      d = d & ~stuck;
      rx_locked = (k == drop_at) ? 1'b0 : 1'b1;
      rx_dpa_locked = d;
      step();
      if (!rx_locked) return;
      if (&d) begin
        e_fifo = '1;
        check_all("fifo_rst");
        ok = 1'b1;
        return;
      end
      if (k == TIMEOUT_CYC) return;
      check_all("dpa_wait");
    end
  endtask

  task automatic phase_fifo_cda(input bit abort, output int r);
    logic [NUM_CH-1:0] q[$];
    if (abort) begin
      do_reset("rst_in_fifo");
      r = 2;
      return;
    end
    for (int i = 1; i < FIFO_RST_CYC; i++) begin
      step();
      check_all("fifo_rst");
    end
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int j = 0; j <= CDA_RST_CYC; j++)
        q.push_back(j < CDA_RST_CYC ? (NUM_CH'(1) << ch) : {NUM_CH{1'b0}});
`ifndef LVDS_INIT_PERCH_CDA_EN
    q.delete();
    for (int j = 0; j < CDA_RST_CYC; j++) q.push_back({NUM_CH{1'b1}});
`endif
    step();
    e_fifo = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) step();
      e_cda = q[i];
      check_all("cda_rst");
    end
    step();
    e_cda = '0;
    e_done = 1'b1;
    check_all("done");
    r = 0;
  endtask

  // attempt modes: 0 succeed, 1 lock never comes, 2 lock drops in DPA wait, 3 DPA timeout
  task automatic run_seq(input int g_at, input int g_len, input bit abort, output int r);
    int mode;
    bit ok;
    r = -1;
    noise = 1'b1;
    for (int a = 0; a < MAX_RETRY; a++) begin
      mode = (fail_plan.size() > 0) ? fail_plan.pop_front() : 0;
      phase_pll();
      phase_wait(mode, (mode == 0) ? g_at : 0, g_len, ok);
      if (ok)
        phase_dpa($urandom_range(1, 12), (mode >= 2) ? stuck_mask : '0,
                  (mode == 2) ? $urandom_range(1, 20) : 0, ok);
      if (ok) begin
        phase_fifo_cda(abort, r);
        return;
      end
      rx_locked = 1'b1;
      e_retry++;
      e_pll = 1'b1;
      e_rxr = 1'b1;
      if (e_retry == MAX_RETRY) begin
        e_err = 1'b1;
        noise = 1'b0;
        start = 1'b0;
        check_all("fail");
        r = 1;
        return;
      end
      check_all("retry");
    end
  endtask

  task automatic hold_done(input int n);
    noise = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check_all("done_hold");
    end
  endtask

  task automatic drop_lock_in_done();
    rx_locked = 1'b0;
    step();
    rx_locked = 1'b1;
    e_done = 1'b0; e_ll = 1'b1; e_retry = 0; e_pll = 1'b1; e_rxr = 1'b1;
    check_all("lock_lost");
  endtask

  initial begin
    set_reset_exp();
    #12;
    check_all("reset");
    @(negedge inclock);
    rst_n = 1'b1;
    step();
    check_all("idle");
    step();
    check_all("idle2");

    begin_run("start_nominal");
    run_seq(0, 0, 1'b0, res);
    hold_done(5);

    drop_lock_in_done();
    run_seq(16, $urandom_range(1, 3), 1'b0, res);
    hold_done(3);

    do_reset("rst_in_done");
    begin_run("start_retry");
    stuck_mask = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
    fail_plan = '{1, 2};
    run_seq(0, 0, 1'b1, res);

    begin_run("start_one_fail");
    fail_plan = '{2};
    run_seq(0, 0, 1'b0, res);
    hold_done(2);
    drop_lock_in_done();
    run_seq($urandom_range(3, 18), $urandom_range(1, 4), 1'b0, res);

    do_reset("rst_before_timeout");
    begin_run("start_timeout");
    stuck_mask = NUM_CH'(4);
    fail_plan = '{3, 3, 3};
    run_seq(0, 0, 1'b0, res);
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("fail_hold");
    end
    begin_run("restart_from_fail");
    run_seq(0, 0, 1'b0, res);
    hold_done(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
